branch_predictor: RTL and testbench

- Fetch-side branch direction predictor, directly upstream of branch resolution.
- Supplies the predicted `taken` bit that resolution compares against the Z/N/OV flags.
- Consumes resolution's `miss` to train a table of 2-bit saturating counters and to flush the in-flight prediction.
- Keeps branch and mispredict statistics counters for performance debug.

---
 rtl/branch_predictor.sv | 129 ++++++++++++
 tb/tb_branch_predictor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch direction predictor built on a table of 2-bit saturating counters.
// The table is trained by branch resolution, and a mispredict flushes the in-flight prediction.
// Branch and mispredict statistics counters saturate at all-ones.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into the index (gshare).
module branch_predictor #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_stall,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic             res_miss,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned DEPTH = 32'(1) << IDX_W;

  logic [1:0]       r_ctr [DEPTH];
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_pred_idx;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_actual;
  logic [1:0]       w_old;
  logic [1:0]       w_new;
  logic             w_bypass;
  logic [1:0]       w_rd;
  logic             w_flush;
  logic             w_unused_pc;

  assign w_pc_idx    = fetch_pc[IDX_W-1:0];
  assign w_unused_pc = ^fetch_pc[PC_W-1:IDX_W];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  assign w_idx = w_pc_idx ^ r_ghr;

  // Global history: shift in each resolved outcome
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (res_valid) begin
      r_ghr <= {r_ghr[IDX_W-2:0], w_actual};
    end
  end
`else
  assign w_idx = w_pc_idx;
`endif

  assign w_actual = res_taken ^ res_miss;
  assign w_old    = r_ctr[res_idx];
  assign w_flush  = res_valid && res_miss;

  // Saturating counter update for the resolving entry
  always_comb begin
    w_new = w_old;
    if (w_actual) begin
      if (w_old != 2'b11) w_new = w_old + 2'd1;
    end else begin
      if (w_old != 2'b00) w_new = w_old - 2'd1;
    end
  end

  // Write-first bypass when fetch reads the entry being trained
  assign w_bypass = fetch_valid && res_valid && (res_idx == w_idx);
  assign w_rd     = w_bypass ? w_new : r_ctr[w_idx];

  // Counter table: reset to weakly not-taken, one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ctr[IDX_W'(i)] <= 2'b01;
      end
    end else if (res_valid) begin
      r_ctr[res_idx] <= w_new;
    end
  end

  // Prediction register with stall hold and mispredict flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      if (!fetch_stall) begin
        r_pred_valid <= fetch_valid;
        if (fetch_valid) begin
          r_pred_taken <= w_rd[1];
          r_pred_idx   <= w_idx;
        end
      end
      if (w_flush) r_pred_valid <= 1'b0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (res_valid) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (res_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_idx   = r_pred_idx;
  assign branch_cnt = r_branch_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [15:0] fetch_pc;
  logic        fetch_stall;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        res_valid;
  logic [5:0]  res_idx;
  logic        res_taken;
  logic        res_miss;
  logic [15:0] branch_cnt;
  logic [15:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  branch_predictor dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
    .res_valid(res_valid), .res_idx(res_idx), .res_taken(res_taken), .res_miss(res_miss),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Model state: counters as integers 0..3, history as an integer
  int m_ctr [64];
  int m_hist;
  bit m_pv, m_pt;
  int m_pi, m_br, m_ms;

  function automatic int trained(int c, bit a);
    if (a) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic int idx_of(int pc);
`ifdef BP_GSHARE_EN
    return (pc ^ m_hist) & 63;
`else
    return pc & 63;
`endif
  endfunction

  // Counter value fetch sees, including an entry being trained this cycle
  function automatic int seen_ctr(int i);
    if (res_valid && int'(res_idx) == i) return trained(m_ctr[i], res_taken ^ res_miss);
    return m_ctr[i];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_ctr[i] <= 1;
      m_hist <= 0; m_pv <= 1'b0; m_pt <= 1'b0; m_pi <= 0; m_br <= 0; m_ms <= 0;
    end else begin
      if (!fetch_stall && fetch_valid) begin
        m_pi <= idx_of(int'(fetch_pc));
        m_pt <= (seen_ctr(idx_of(int'(fetch_pc))) >= 2);
      end
      if (res_valid && res_miss) m_pv <= 1'b0;
      else if (!fetch_stall)     m_pv <= fetch_valid;
      if (res_valid) begin
        m_ctr[res_idx] <= trained(m_ctr[res_idx], res_taken ^ res_miss);
        m_hist <= ((m_hist << 1) | int'(res_taken ^ res_miss)) & 63;
        m_br <= (m_br >= 65535) ? 65535 : m_br + 1;
        if (res_miss) m_ms <= (m_ms >= 65535) ? 65535 : m_ms + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_pred_valid", 32'(pred_valid), 32'(m_pv));
      check("mdl_pred_taken", 32'(pred_taken), 32'(m_pt));
      check("mdl_pred_idx",   32'(pred_idx),   32'(m_pi));
      check("mdl_branch_cnt", 32'(branch_cnt), 32'(m_br));
      check("mdl_miss_cnt",   32'(miss_cnt),   32'(m_ms));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int exp_a;

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_stall = 1'b0;
    res_valid = 1'b0; res_idx = '0; res_taken = 1'b0; res_miss = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_idx",   32'(pred_idx),   32'd0);
    check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    rst = 1'b0;

    // First prediction from reset table
    fetch_valid = 1'b1; fetch_pc = 16'h0005;
    step();
    check("t1_pred_valid", 32'(pred_valid), 32'd1);
    check("t1_pred_taken", 32'(pred_taken), 32'd0);
    check("t1_pred_idx",   32'(pred_idx),   32'd5);
    check("t1_miss_cnt",   32'(miss_cnt),   32'd0);
    fetch_valid = 1'b0;

    // Train entry 5 to saturation with three misses
    res_valid = 1'b1; res_idx = 6'd5; res_taken = 1'b0; res_miss = 1'b1;
    repeat (3) step();
    res_valid = 1'b0; res_miss = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 16'h0005;
    step();
`ifdef BP_GSHARE_EN
    check("t2_pred_idx",   32'(pred_idx),   32'd2);
    check("t2_pred_taken", 32'(pred_taken), 32'd0);
`else
    check("t2_pred_idx",   32'(pred_idx),   32'd5);
    check("t2_pred_taken", 32'(pred_taken), 32'd1);
`endif
    check("t2_branch_cnt", 32'(branch_cnt), 32'd3);
    check("t2_miss_cnt",   32'(miss_cnt),   32'd3);
    fetch_valid = 1'b0;

    // Same-cycle collision: bypass plus flush
    do_reset();
    fetch_valid = 1'b1; fetch_pc = 16'h0009;
    res_valid = 1'b1; res_idx = 6'd9; res_taken = 1'b0; res_miss = 1'b1;
    step();
    check("t3_pred_taken", 32'(pred_taken), 32'd1);
    check("t3_pred_valid", 32'(pred_valid), 32'd0);
    check("t3_pred_idx",   32'(pred_idx),   32'd9);
    res_valid = 1'b0; res_miss = 1'b0;

    // Stall holds outputs; a miss during stall still flushes
    fetch_pc = 16'h000A;
    step();
`ifdef BP_GSHARE_EN
    exp_a = 11;
`else
    exp_a = 10;
`endif
    check("t4_pred_valid", 32'(pred_valid), 32'd1);
    check("t4_pred_idx",   32'(pred_idx),   32'(exp_a));
    fetch_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch_valid = (k % 2) == 1;
      fetch_pc    = 16'(16'h0020 + k);
      step();
      check("t4_stall_valid", 32'(pred_valid), 32'd1);
      check("t4_stall_idx",   32'(pred_idx),   32'(exp_a));
      check("t4_stall_taken", 32'(pred_taken), 32'd0);
    end
    fetch_valid = 1'b1;
    res_valid = 1'b1; res_idx = 6'd3; res_taken = 1'b1; res_miss = 1'b1;
    step();
    check("t4_flush_valid", 32'(pred_valid), 32'd0);
    check("t4_flush_idx",   32'(pred_idx),   32'(exp_a));
    res_valid = 1'b0; res_miss = 1'b0; fetch_stall = 1'b0; fetch_valid = 1'b0;

    // Statistics saturation, then reset mid-stream
    do_reset();
    res_valid = 1'b1; res_idx = 6'd0; res_taken = 1'b0; res_miss = 1'b1;
    repeat (65534) step();
    check("t5_miss_fffe", 32'(miss_cnt), 32'h0000_FFFE);
    repeat (3) step();
    check("t5_miss_sat",   32'(miss_cnt),   32'h0000_FFFF);
    check("t5_branch_sat", 32'(branch_cnt), 32'h0000_FFFF);
    rst = 1'b1; fetch_valid = 1'b1; fetch_pc = 16'h0000;
    step();
    check("t5_rst_miss",   32'(miss_cnt),   32'd0);
    check("t5_rst_branch", 32'(branch_cnt), 32'd0);
    check("t5_rst_valid",  32'(pred_valid), 32'd0);
    rst = 1'b0; res_valid = 1'b0; res_miss = 1'b0;
    step();
    check("t5_tbl_taken", 32'(pred_taken), 32'd0);
    check("t5_tbl_idx",   32'(pred_idx),   32'd0);
    fetch_valid = 1'b0;

    // History hashing into the index
    do_reset();
    res_valid = 1'b1; res_idx = 6'd0; res_taken = 1'b1; res_miss = 1'b0;
    repeat (2) step();
    res_valid = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 16'h0001;
    step();
`ifdef BP_GSHARE_EN
    check("t6_pred_idx", 32'(pred_idx), 32'd2);
`else
    check("t6_pred_idx", 32'(pred_idx), 32'd1);
`endif
    check("t6_pred_taken", 32'(pred_taken), 32'd0);
    check("t6_branch_cnt", 32'(branch_cnt), 32'd2);
    fetch_valid = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
